// File: rtl/mcp3008_scheduler.sv
// mcp3008_scheduler
//   Shares one MCP3008 serial-interface engine between NUM_REQ requesters.
//   A round-robin arbiter picks one pending request, strobes the ADC engine,
//   watches its busy flag with timeouts, returns the result to the winner and
//   then holds off for GUARD_CYC cycles so chip select gets its high time.
//
// Ports
//   clk        single clock (ADC data clock), posedge
//   rst        asynchronous active-high reset
//   req        per-requester level request, held until its done pulse
//   req_chan   per-requester channel select, requester i on [3i+2:3i]
//   gnt        one-hot grant, from the arbitration decision through the done cycle
//   done       one-cycle completion pulse to the granted requester
//   err        high with done when the conversion timed out
//   result     10-bit result, updated on successful done, held otherwise
//   adc_start  one-cycle start strobe to the ADC engine
//   adc_chan   channel for the ADC configuration word, latched at grant
//   adc_busy   busy flag from the ADC engine
//   adc_data   result register of the ADC engine
module mcp3008_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 8,
  parameter int CONV_TIMEOUT = 64,
  parameter int GUARD_CYC    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [3*NUM_REQ-1:0]   req_chan,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [9:0]             result,
  output logic                   adc_start,
  output logic [2:0]             adc_chan,
  input  logic                   adc_busy,
  input  logic [9:0]             adc_data
);

  localparam int TMAX    = (BUSY_TIMEOUT > CONV_TIMEOUT) ? BUSY_TIMEOUT : CONV_TIMEOUT;
  localparam int CNT_MAX = (TMAX > GUARD_CYC) ? TMAX : GUARD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // The counter holds "cycles elapsed since the reference event" (start
  // strobe or busy rise), so a conversion finishes when the next value would
  // reach the timeout and done lands exactly TIMEOUT cycles after the event.
  localparam logic [CW-1:0] BUSY_LAST  = CW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_TIMEOUT - 1);
  // The done cycle is the first guard cycle.
  localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 1) ? GUARD_CYC - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT    = '1;
  localparam logic [NUM_REQ-1:0] GNT0  = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, GUARD} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win;
  logic [IW-1:0]   win_inc;
  logic [CW-1:0]   cnt;

  logic            found;
  logic [IW-1:0]   pick;
  logic [IW:0]     sum;
  logic [2:0]      chan_arr [NUM_REQ];

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CNT_SAT) ? c : c + 1'b1;
  endfunction

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
      assign chan_arr[gi] = req_chan[3*gi +: 3];
    end
  endgenerate

  // Round-robin search upward from ptr, wrapping at NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_REQ)) sum = sum - (IW+1)'(NUM_REQ);
      if (!found && req[sum[IW-1:0]]) begin
        found = 1'b1;
        pick  = sum[IW-1:0];
      end
    end
  end

  assign win_inc = (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      win       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= 1'b0;
      result    <= '0;
      adc_start <= 1'b0;
      adc_chan  <= '0;
    end else begin
      adc_start <= 1'b0;
      done      <= '0;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt       <= GNT0 << pick;
            win       <= pick;
            adc_chan  <= chan_arr[pick];
            adc_start <= 1'b1;
            cnt       <= '0;
            state     <= START;
          end
        end
        START: begin
          cnt   <= sat_inc(cnt);
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (adc_busy) begin
            // The busy-rise cycle itself is cycle 0 of the conversion window.
            cnt   <= CW'(1);
            state <= WAIT_DONE;
          end else if (cnt >= BUSY_LAST) begin
            done  <= gnt;
            err   <= 1'b1;
            ptr   <= win_inc;
            cnt   <= '0;
            state <= GUARD;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        WAIT_DONE: begin
          if (!adc_busy) begin
            done   <= gnt;
            result <= adc_data;
            ptr    <= win_inc;
            cnt    <= '0;
            state  <= GUARD;
          end else if (cnt >= CONV_LAST) begin
            done  <= gnt;
            err   <= 1'b1;
            ptr   <= win_inc;
            cnt   <= '0;
            state <= GUARD;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        GUARD: begin
          gnt <= '0;
          if (cnt >= GUARD_LAST) state <= IDLE;
          else cnt <= sat_inc(cnt);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
